vga_frame_ctrl: RTL
===================

VGA_FRAME_CTRL -- requirements
Module: vga_frame_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, clk cycles per pixel.
REQ-002 The block SHALL have parameter H_TOTAL, default 800, pixels per line.
REQ-003 The block SHALL have parameter H_SYNC, default 96, and H_BP, default 48: hsync width and back porch, in pixels.
REQ-004 The block SHALL have parameter V_TOTAL, default 521, lines per frame.
REQ-005 The block SHALL have parameter V_SYNC, default 2, and V_BP, default 29: vsync width and back porch, in lines.
REQ-006 The block SHALL have these ports, in this order:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- Hsync  out  1  horizontal sync, active-low.
- Vsync  out  1  vertical sync, active-low.
- active  out  1  pixel inside the 640x480 visible window.
- pix_x  out  10  visible column 0..639; 0 when not active.
- pix_y  out  9  visible row 0..479; 0 when not active.
- vblank  out  1  vertical blanking: vcount outside the visible rows.
- upd_req  in  1  game-logic update request (4-phase).
- upd_done  in  1  single-cycle pulse: update finished.
- upd_gnt  out  1  update window granted.
- upd_abort  out  1  single-cycle pulse: grant revoked because blanking ended.
- frame_cnt  out  16  completed-frame counter.

Function
REQ-007 A divider SHALL count 0..CLK_DIV-1 and assert the internal pix_en when it equals CLK_DIV-1.
REQ-008 On pix_en, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment; vcount SHALL wrap from V_TOTAL-1 to 0.
REQ-009 All outputs SHALL be registered and derived from the same counter state; Hsync=0 iff hcount<H_SYNC; Vsync=0 iff vcount<V_SYNC.
REQ-010 active=1 iff hcount is in [H_SYNC+H_BP, H_SYNC+H_BP+640) and vcount is in [V_SYNC+V_BP, V_SYNC+V_BP+480).
REQ-011 When active=1, pix_x SHALL be hcount-(H_SYNC+H_BP) and pix_y SHALL be vcount-(V_SYNC+V_BP).
REQ-012 vblank SHALL be 1 for vcount in [V_SYNC+V_BP+480, V_TOTAL) and [0, V_SYNC+V_BP); this is one contiguous interval across the frame wrap.
REQ-013 The update FSM SHALL have the states IDLE, WAIT, GRANT and DONE.
REQ-014 IDLE: upd_req=1 with vblank=1 SHALL go to GRANT; upd_req=1 with vblank=0 SHALL go to WAIT.
REQ-015 WAIT: upd_req=0 SHALL return to IDLE; otherwise the 0->1 edge of vblank SHALL go to GRANT.
REQ-016 upd_gnt SHALL be 1 only in GRANT.
REQ-017 GRANT: upd_done=1 SHALL go to DONE; otherwise the 1->0 edge of vblank SHALL pulse upd_abort for one cycle and go to DONE.
REQ-018 If upd_done and the vblank falling edge occur in the same cycle, done SHALL win: no upd_abort.
REQ-019 DONE: the FSM SHALL wait for upd_req=0, then go to IDLE; a new grant always requires a fresh request.
REQ-020 upd_done outside GRANT SHALL be ignored.

Reset
REQ-021 rst SHALL set the divider, hcount, vcount and frame_cnt to 0 and the FSM to IDLE.
REQ-022 During and on the cycle after rst: Hsync=1, Vsync=1, active=0, pix_x=0, pix_y=0, vblank=0, upd_gnt=0, upd_abort=0.
REQ-023 rst asserted mid-grant SHALL drop upd_gnt on the next edge, without pulsing upd_abort.

Configuration
REQ-024 When VGA_FRAME_CNT_EN is defined, frame_cnt SHALL increment, wrapping modulo 2^16, on each vcount wrap to 0.
REQ-025 When VGA_FRAME_CNT_EN is undefined, frame_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-026 A shared package SHALL hold the timing defaults (640, 480, H_* and V_* values) and the FSM state encoding.
REQ-027 The counter/sync logic SHALL be a sub-module vga_timing_core; the update FSM SHALL live in vga_frame_ctrl.

Verification
REQ-028 After reset with defaults: Hsync low for 384 clk out of every 3200; Vsync low for 6400 clk out of every 1,667,200.
REQ-029 Exactly 640 active pixels per visible line and 480 visible lines; first active pixel has pix_x=0, pix_y=0 at hcount=144, vcount=31.
REQ-030 upd_req raised at vcount=100 -> upd_gnt rises on the first cycle with vblank=1 (vcount=511, hcount=0).
REQ-031 Grant held with no upd_done -> one-cycle upd_abort and upd_gnt=0 as vcount reaches 31.
REQ-032 upd_done coincident with the vblank falling edge -> no upd_abort; FSM in DONE; no re-grant until upd_req drops and rises again.
REQ-033 rst pulsed mid-GRANT -> upd_gnt=0 and counters 0 next cycle; with VGA_FRAME_CNT_EN, frame_cnt=3 after three full frames.

Source files
------------

// File: rtl/vga_frame_ctrl_pkg.sv
// Shared VGA 640x480 timing defaults and update-FSM encoding.
// Optional frame counter: define VGA_FRAME_CNT_EN.
package vga_frame_ctrl_pkg;

  localparam int H_VIS_DEF   = 640;
  localparam int V_VIS_DEF   = 480;
  localparam int CLK_DIV_DEF = 4;
  localparam int H_TOTAL_DEF = 800;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_TOTAL_DEF = 521;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 29;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT,
    S_DONE
  } upd_state_t;

endpackage

// File: rtl/vga_timing_core.sv
// Pixel divider, h/v counters and registered sync/window outputs.
// Frame counter present only with VGA_FRAME_CNT_EN defined.
module vga_timing_core #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_VIS   = 640,
  parameter int V_TOTAL = 521,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 29,
  parameter int V_VIS   = 480
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        vblank,
  output logic        vblank_nxt,
  output logic [15:0] frame_cnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_W   = 10'(H_SYNC);
  localparam logic [9:0] VS_W   = 10'(V_SYNC);
  localparam logic [9:0] H_ST   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_EN   = 10'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0] V_ST   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_EN   = 10'(V_SYNC + V_BP + V_VIS);

  logic [DW-1:0] div;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic          pix_en;
  logic          h_wrap;
  logic          h_act;
  logic          v_act;
  logic          act_nxt;
  logic [9:0]    hx;
  logic [8:0]    vy;

  assign pix_en = (div == D_LAST);
  assign h_wrap = pix_en & (hcount == H_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= pix_en ? '0 : div + DW'(1);
      if (pix_en)
        hcount <= h_wrap ? '0 : hcount + 10'd1;
      if (h_wrap)
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end
  end

  assign h_act      = (hcount >= H_ST) && (hcount < H_EN);
  assign v_act      = (vcount >= V_ST) && (vcount < V_EN);
  assign act_nxt    = h_act & v_act;
  assign vblank_nxt = ~v_act;
  assign hx         = hcount - H_ST;
  // Visible rows fit in 9 bits, so the low-bit difference is exact.
  assign vy         = vcount[8:0] - V_ST[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      active <= 1'b0;
      pix_x  <= '0;
      pix_y  <= '0;
      vblank <= 1'b0;
    end else begin
      hsync  <= ~(hcount < HS_W);
      vsync  <= ~(vcount < VS_W);
      active <= act_nxt;
      pix_x  <= act_nxt ? hx : '0;
      pix_y  <= act_nxt ? vy : '0;
      vblank <= vblank_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic        f_wrap;
  logic [15:0] fcnt;

  assign f_wrap = h_wrap & (vcount == V_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      fcnt <= '0;
    else if (f_wrap)
      fcnt <= fcnt + 16'd1;
  end

  assign frame_cnt = fcnt;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame controller: timing core plus blanking-window update arbiter.
// Frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_frame_ctrl
  import vga_frame_ctrl_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int V_VIS   = V_VIS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        Hsync,
  output logic        Vsync,
  output logic        active,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        vblank,
  input  logic        upd_req,
  input  logic        upd_done,
  output logic        upd_gnt,
  output logic        upd_abort,
  output logic [15:0] frame_cnt
);

  upd_state_t state;
  upd_state_t state_nxt;
  logic       vblank_nxt;
  logic       vb_rise;
  logic       vb_fall;
  logic       abort_nxt;

  vga_timing_core #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .H_VIS   (H_VIS),
    .V_TOTAL (V_TOTAL),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .V_VIS   (V_VIS)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .hsync      (Hsync),
    .vsync      (Vsync),
    .active     (active),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .vblank     (vblank),
    .vblank_nxt (vblank_nxt),
    .frame_cnt  (frame_cnt)
  );

  // Edges are seen one cycle early so grant/abort line up with vblank.
  assign vb_rise = vblank_nxt & ~vblank;
  assign vb_fall = vblank & ~vblank_nxt;

  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    unique case (state)
      S_IDLE:
        if (upd_req)
          state_nxt = vblank_nxt ? S_GRANT : S_WAIT;
      S_WAIT:
        if (!upd_req)
          state_nxt = S_IDLE;
        else if (vb_rise)
          state_nxt = S_GRANT;
      S_GRANT:
        if (upd_done) begin
          state_nxt = S_DONE;
        end else if (vb_fall) begin
          state_nxt = S_DONE;
          abort_nxt = 1'b1;
        end
      S_DONE:
        if (!upd_req)
          state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      upd_gnt   <= 1'b0;
      upd_abort <= 1'b0;
    end else begin
      state     <= state_nxt;
      upd_gnt   <= (state_nxt == S_GRANT);
      upd_abort <= abort_nxt;
    end
  end

endmodule
